// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes, registered flags and an optional
// iterative shift-add multiplier that shares the output register.
module alu_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             Carry,
   output logic             Illegal
);

   localparam int unsigned SHW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]         state, state_n;
   logic [SHW-1:0]     cnt, cnt_n;
   logic [2*WIDTH-1:0] mcand, mcand_n;
   logic [WIDTH-1:0]   mplier, mplier_n;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [2*WIDTH-1:0] mul_step;

   logic             out_free, accept, is_mul, load, out_valid_n;
   logic [WIDTH-1:0] ld_res;
   logic             ld_ovf, ld_cry, ld_ill;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf, alu_cry, alu_ill;
   logic [WIDTH:0]   add_w, sub_w;
   logic [SHW-1:0]   shamt;

   assign out_free = !out_valid || out_ready;
   assign in_ready = (state == S_IDLE) && out_free;
   assign accept   = in_valid && in_ready;
   assign is_mul   = (ALUOp == 4'd11) && MUL_EN;
   assign mul_step = acc + (mplier[0] ? mcand : '0);

   // single-cycle operations and their flags
   always_comb begin
      add_w   = {1'b0, A} + {1'b0, B};
      sub_w   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
      shamt   = B[SHW-1:0];
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_cry = 1'b0;
      alu_ill = 1'b0;
      case (ALUOp)
         4'd0: begin
            alu_res = add_w[WIDTH-1:0];
            alu_cry = add_w[WIDTH];
            alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
         end
         4'd1: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_cry = sub_w[WIDTH];
            alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
         end
         4'd2:  alu_res = A & B;
         4'd3:  alu_res = A | B;
         4'd4:  alu_res = A ^ B;
         4'd5:  alu_res = ~(A | B);
         4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         4'd8:  alu_res = A << shamt;
         4'd9:  alu_res = A >> shamt;
         4'd10: alu_res = $signed(A) >>> shamt;
         4'd11: alu_ill = !MUL_EN;
         default: alu_ill = 1'b1;
      endcase
   end

   // multiply FSM and output-register load control
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mcand_n  = mcand;
      mplier_n = mplier;
      acc_n    = acc;
      load     = 1'b0;
      ld_res   = alu_res;
      ld_ovf   = alu_ovf;
      ld_cry   = alu_cry;
      ld_ill   = alu_ill;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_n  = S_MUL;
                  mcand_n  = {{WIDTH{1'b0}}, A};
                  mplier_n = B;
                  acc_n    = '0;
                  cnt_n    = '0;
               end else begin
                  load = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_n    = mul_step;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + SHW'(1);
            if (cnt == SHW'(WIDTH-1)) begin
               if (out_free) begin
                  load    = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  state_n = S_HOLD;
               end
               ld_res = mul_step[WIDTH-1:0];
               ld_cry = |mul_step[2*WIDTH-1:WIDTH];
               ld_ovf = 1'b0;
               ld_ill = 1'b0;
            end
         end
         S_HOLD: begin
            ld_res = acc[WIDTH-1:0];
            ld_cry = |acc[2*WIDTH-1:WIDTH];
            ld_ovf = 1'b0;
            ld_ill = 1'b0;
            if (out_free) begin
               load    = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      out_valid_n = load || (out_valid && !out_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         Result    <= '0;
         Zero      <= 1'b1;
         Overflow  <= 1'b0;
         Carry     <= 1'b0;
         Illegal   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         mcand     <= mcand_n;
         mplier    <= mplier_n;
         acc       <= acc_n;
         out_valid <= out_valid_n;
         if (load) begin
            Result   <= ld_res;
            Zero     <= (ld_res == '0);
            Overflow <= ld_ovf;
            Carry    <= ld_cry;
            Illegal  <= ld_ill;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, stall/reset
// sequences, and randomized streams scored against an arithmetic model.
module tb_alu_pipe;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        ovf;
      logic        cry;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_valid0 = 1'b0;
   logic        in_ready, in_ready0;
   logic [31:0] A = '0, B = '0;
   logic [3:0]  ALUOp = '0;
   logic        out_valid, out_valid0;
   logic        out_ready = 1'b1;
   logic [31:0] Result, Result0;
   logic        Zero, Overflow, Carry, Illegal;
   logic        Zero0, Overflow0, Carry0, Illegal0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Zero(Zero), .Overflow(Overflow), .Carry(Carry), .Illegal(Illegal)
   );

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid0), .out_ready(out_ready),
      .Result(Result0), .Zero(Zero0), .Overflow(Overflow0), .Carry(Carry0), .Illegal(Illegal0)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      int          sa, sb;
      longint      s;
      logic [63:0] ua, ub, full;
      sa = a; sb = b; ua = {32'd0, a}; ub = {32'd0, b};
      e = '0;
      case (op)
         4'd0: begin e.res = a + b; e.cry = (ua + ub) > 64'hFFFF_FFFF;
                     s = longint'(sa) + longint'(sb); e.ovf = (s != longint'(int'(s))); end
         4'd1: begin e.res = a - b; e.cry = (a >= b);
                     s = longint'(sa) - longint'(sb); e.ovf = (s != longint'(int'(s))); end
         4'd2:  e.res = a & b;
         4'd3:  e.res = a | b;
         4'd4:  e.res = a ^ b;
         4'd5:  e.res = ~(a | b);
         4'd6:  e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd7:  e.res = (a < b) ? 32'd1 : 32'd0;
         4'd8:  e.res = a << b[4:0];
         4'd9:  e.res = a >> b[4:0];
         4'd10: e.res = sa >>> b[4:0];
         4'd11: begin full = ua * ub; e.res = full[31:0]; e.cry = (full[63:32] != 0); end
         default: e.ill = 1'b1;
      endcase
      e.z = (e.res == 0);
      return e;
   endfunction

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic z, input logic o,
                               input logic c, input logic i, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.lat = lat;
      v.e.res = res; v.e.z = z; v.e.ovf = o; v.e.cry = c; v.e.ill = i;
      return v;
   endfunction

   function automatic exp_t cur();
      exp_t e;
      e.res = Result; e.z = Zero; e.ovf = Overflow; e.cry = Carry; e.ill = Illegal;
      return e;
   endfunction

   // one transaction with out_ready=1; returns captured outputs and cycles from accept
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t got, output int lat);
      int t = 0;
      ALUOp = op; A = a; B = b; in_valid = 1'b1;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      got = cur();
   endtask

   task automatic pick(input bit add_only);
      ALUOp = add_only ? 4'd0 : 4'($urandom_range(0, 15));
      A = $urandom;
      B = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
   endtask

   // randomized stream with random backpressure and input bubbles
   task automatic stream(input int n, input bit add_only, input string tag);
      exp_t        q[$];
      exp_t        e, snapf;
      int          sent = 0, rcv = 0, cyc = 0;
      bit          acc, drn, stall;
      pick(add_only);
      in_valid = 1'b1;
      while (rcv < n && cyc < 5000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         #0;
         acc   = in_valid && in_ready;
         drn   = out_valid && out_ready;
         stall = out_valid && !out_ready;
         snapf = cur();
         if (acc) q.push_back(model(ALUOp, A, B));
         @(posedge clk); #1; cyc++;
         if (drn) begin
            if (q.size() == 0) chk({tag, "_spurious"}, 64'(snapf), 64'hFFFF_FFFF_FFFF);
            else begin
               e = q.pop_front();
               chk({tag, "_result"}, 64'(snapf), 64'(e));
            end
            rcv++;
         end
         if (stall) chk({tag, "_stable"}, {27'd0, out_valid, cur()}, {27'd0, 1'b1, snapf});
         if (acc) sent++;
         if (sent >= n) in_valid = 1'b0;
         else if (acc || !in_valid) begin
            pick(add_only);
            in_valid = ($urandom_range(0, 4) != 0);
         end
      end
      chk({tag, "_count"}, 64'(rcv), 64'(n));
      chk({tag, "_leftover"}, 64'(q.size()), 64'd0);
      out_ready = 1'b1;
   endtask

   initial begin
      vec_t tbl[15];
      exp_t got, r;
      int   lat, t;
      bit   stable, stale;

      tbl[0]  = mk(4'd0,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0, 0, 1);
      tbl[1]  = mk(4'd1,  32'd5, 32'd5, 32'd0, 1, 0, 1, 0, 1);
      tbl[2]  = mk(4'd6,  32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 0, 1);
      tbl[3]  = mk(4'd7,  32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 0, 0, 1);
      tbl[4]  = mk(4'd10, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 0, 0, 0, 1);
      tbl[5]  = mk(4'd9,  32'h8000_0000, 32'h24, 32'h0800_0000, 0, 0, 0, 0, 1);
      tbl[6]  = mk(4'd8,  32'h8000_0000, 32'h24, 32'd0, 1, 0, 0, 0, 1);
      tbl[7]  = mk(4'd11, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, 0, 1, 0, 33);
      tbl[8]  = mk(4'd11, 32'd1234, 32'd5678, 32'd7006652, 0, 0, 0, 0, 33);
      tbl[9]  = mk(4'd13, 32'h1234_5678, 32'h9, 32'd0, 1, 0, 0, 1, 1);
      tbl[10] = mk(4'd0,  32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1, 0, 1);
      tbl[11] = mk(4'd1,  32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
      tbl[12] = mk(4'd1,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 1, 0, 1);
      tbl[13] = mk(4'd5,  32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
      tbl[14] = mk(4'd4,  32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F, 0, 0, 0, 0, 1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {27'd0, out_valid, cur()}, {27'd0, 1'b0, 32'd0, 1'b1, 3'b000});
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // MUL disabled variant flags op 11 as illegal
      chk("mul_dis_in_ready", 64'(in_ready0), 64'd1);
      ALUOp = 4'd11; A = 32'd3; B = 32'd5; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      chk("mul_dis_valid", 64'(out_valid0), 64'd1);
      chk("mul_dis_flags", {28'd0, Result0, Zero0, Overflow0, Carry0, Illegal0},
          {28'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1});

      // directed vectors
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, got, lat);
         chk($sformatf("vec%0d_op%0d", i, tbl[i].op), 64'(got), 64'(tbl[i].e));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      end
      @(posedge clk); #1;
      chk("drain_clears_valid", 64'(out_valid), 64'd0);

      // MUL result held under backpressure; ADD offered while blocked wins on release
      ALUOp = 4'd11; A = 32'd3; B = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      t = 0;
      while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
      chk("hold_mul_latency", 64'(t), 64'd32);
      r = cur();
      chk("hold_mul_result", 64'(r), 64'(model(4'd11, 32'd3, 32'd5)));
      ALUOp = 4'd0; A = 32'd100; B = 32'd23; in_valid = 1'b1;
      stable = 1'b1;
      repeat (5) begin
         if (in_ready) stable = 1'b0;
         @(posedge clk); #1;
         if (!out_valid || cur() != r) stable = 1'b0;
      end
      chk("hold_stable_blocked", 64'(stable), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("drain_and_load_valid", 64'(out_valid), 64'd1);
      chk("drain_and_load_result", 64'(cur()), 64'(model(4'd0, 32'd100, 32'd23)));
      @(posedge clk); #1;
      chk("final_drain", 64'(out_valid), 64'd0);

      // reset mid-multiply discards the product
      ALUOp = 4'd11; A = 32'hFFFF; B = 32'hFFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midmul_reset_outputs", {27'd0, out_valid, cur()}, {27'd0, 1'b0, 32'd0, 1'b1, 3'b000});
      @(negedge clk) rst = 1'b1;
      #1;
      chk("midmul_in_ready", 64'(in_ready), 64'd1);
      stale = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) stale = 1'b1; end
      chk("midmul_no_stale", 64'(stale), 64'd0);

      // streaming
      stream(8, 1'b1, "add_stream");
      stream(40, 1'b0, "rand_stream");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
